// File: rtl/qpsk_pkg.sv
// Shared constants and types for the QPSK carrier modulator.
package qpsk_pkg;

   localparam int SW         = 11;
   localparam int OW         = 12;
   localparam int PERIOD     = 100;
   localparam int DELAY      = 75;
   localparam int SYM_CYCLES = 1;

   typedef enum logic {
      UNLOCKED,
      RUN
   } state_t;

   // A symbol carries its own valid bit; an invalid symbol (IDLE) forces a zero output.
   typedef struct packed {
      logic vld;
      logic i_neg;
      logic q_neg;
   } sym_t;

   localparam sym_t SYM_IDLE = '0;

   // Dibit bit value to carrier sign: 0 selects +1, 1 selects -1.
   localparam logic SIGN_POS = 1'b0;
   localparam logic SIGN_NEG = 1'b1;

endpackage

// File: rtl/qpsk_sample_delay.sv
// Fixed-length sample delay built as a circular buffer; dout is the sample written DELAY cycles ago.
module qpsk_sample_delay
   import qpsk_pkg::*;
#(
   parameter int SW    = qpsk_pkg::SW,
   parameter int DELAY = qpsk_pkg::DELAY
) (
   input  logic                 Clk,
   input  logic                 Rst_n,
   input  logic signed [SW-1:0] din,
   output logic signed [SW-1:0] dout
);

   localparam int AW = $clog2(DELAY);
   localparam logic [AW-1:0] PTR_LAST = AW'(DELAY - 1);

   logic signed [SW-1:0] mem [DELAY];
   logic [AW-1:0]        wr_ptr;

   // The slot about to be overwritten holds the oldest sample, so read it before the write.
   assign dout = mem[wr_ptr];

   // Write pointer wraps over the DELAY slots.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         wr_ptr <= '0;
      end else if (wr_ptr == PTR_LAST) begin
         wr_ptr <= '0;
      end else begin
         wr_ptr <= wr_ptr + 1'b1;
      end
   end

   // Storage is written every cycle; contents are not reset.
   always_ff @(posedge Clk) begin
      mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/qpsk_carrier_mod.sv
// QPSK modulator: locks to the sine carrier's rising zero crossing, derives cosine by a
// 3/4-period delay and emits I*cos + Q*sin per dibit received over a valid/ready handshake.
module qpsk_carrier_mod
   import qpsk_pkg::*;
#(
   parameter int SW         = qpsk_pkg::SW,
   parameter int PERIOD     = qpsk_pkg::PERIOD,
   parameter int DELAY      = qpsk_pkg::DELAY,
   parameter int SYM_CYCLES = qpsk_pkg::SYM_CYCLES,
   parameter int OW         = qpsk_pkg::OW
) (
   input  logic                 Clk,
   input  logic                 Rst_n,
   input  logic signed [SW-1:0] sin_in,
   input  logic [1:0]           sym_data,
   input  logic                 sym_valid,
   output logic                 sym_ready,
   output logic signed [OW-1:0] mod_out,
   output logic                 mod_valid,
   output logic                 sym_start,
   output logic                 underrun,
   output logic                 lock_err
);

   localparam int PW = $clog2(PERIOD);
   localparam int FW = $clog2(DELAY + 1);
   localparam int CW = $clog2(SYM_CYCLES + 1);
   localparam logic [PW-1:0] PH_LAST  = PW'(PERIOD - 1);
   localparam logic [PW-1:0] PH_ONE   = PW'(1);
   localparam logic [FW-1:0] FILL_MAX = FW'(DELAY);
   localparam logic [CW-1:0] CNT_LAST = CW'(SYM_CYCLES - 1);

   state_t               state;
   logic [PW-1:0]        phase;
   logic [CW-1:0]        sym_cnt;
   logic [FW-1:0]        fill_cnt;
   logic signed [SW-1:0] prev;
   logic signed [SW-1:0] cos_s;
   sym_t                 cur_sym;
   sym_t                 sym_eff;
   logic [1:0]           hold;
   logic                 hold_valid;

   logic                 fill_done;
   logic                 xing;
   logic                 entering;
   logic                 fail;
   logic                 boundary;
   logic                 run_eff;
   logic                 take_hold;
   logic                 take_bypass;
   logic                 load_hold;
   logic signed [OW-1:0] ext_cos;
   logic signed [OW-1:0] ext_sin;
   logic signed [OW-1:0] term_i;
   logic signed [OW-1:0] term_q;
   logic signed [OW-1:0] mod_next;

   qpsk_sample_delay #(
      .SW    (SW),
      .DELAY (DELAY)
   ) u_delay (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .din   (sin_in),
      .dout  (cos_s)
   );

   assign sym_ready = !hold_valid;

   // Lock/boundary decisions and the sample for this cycle. The lock-check failure cycle is
   // treated as already unlocked, so it produces no valid sample.
   always_comb begin
      fill_done   = (fill_cnt == FILL_MAX);
      xing        = (sin_in == '0) && prev[SW-1];
      entering    = (state == UNLOCKED) && xing && fill_done;
      fail        = (state == RUN) && (phase == '0) && !xing;
      boundary    = entering || ((state == RUN) && (phase == '0) && (sym_cnt == '0) && xing);
      run_eff     = entering || ((state == RUN) && !fail);
      take_hold   = boundary && hold_valid;
      take_bypass = boundary && !hold_valid && sym_valid;
      load_hold   = !boundary && sym_valid && !hold_valid;

      sym_eff = cur_sym;
      if (take_hold) begin
         sym_eff = '{vld: 1'b1, i_neg: hold[1], q_neg: hold[0]};
      end else if (take_bypass) begin
         sym_eff = '{vld: 1'b1, i_neg: sym_data[1], q_neg: sym_data[0]};
      end else if (boundary || fail) begin
         sym_eff = SYM_IDLE;
      end

      ext_cos  = OW'(cos_s);
      ext_sin  = OW'(sin_in);
      term_i   = (sym_eff.i_neg == SIGN_NEG) ? -ext_cos : ext_cos;
      term_q   = (sym_eff.q_neg == SIGN_POS) ? ext_sin : -ext_sin;
      mod_next = (run_eff && sym_eff.vld) ? (term_i + term_q) : '0;
   end

   // Lock FSM, symbol timing, dibit holding register and registered outputs.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state      <= UNLOCKED;
         phase      <= '0;
         sym_cnt    <= '0;
         fill_cnt   <= '0;
         prev       <= '0;
         cur_sym    <= SYM_IDLE;
         hold       <= '0;
         hold_valid <= 1'b0;
         mod_out    <= '0;
         mod_valid  <= 1'b0;
         sym_start  <= 1'b0;
         underrun   <= 1'b0;
         lock_err   <= 1'b0;
      end else begin
         prev    <= sin_in;
         cur_sym <= sym_eff;
         if (!fill_done) begin
            fill_cnt <= fill_cnt + 1'b1;
         end

         if (take_hold) begin
            hold_valid <= 1'b0;
         end else if (load_hold) begin
            hold       <= sym_data;
            hold_valid <= 1'b1;
         end

         case (state)
            UNLOCKED: begin
               if (entering) begin
                  state   <= RUN;
                  phase   <= PH_ONE;
                  sym_cnt <= '0;
               end
            end
            RUN: begin
               if (fail) begin
                  state   <= UNLOCKED;
                  phase   <= '0;
                  sym_cnt <= '0;
               end else if (phase == PH_LAST) begin
                  phase   <= '0;
                  sym_cnt <= (sym_cnt == CNT_LAST) ? '0 : sym_cnt + 1'b1;
               end else begin
                  phase <= phase + 1'b1;
               end
            end
            default: state <= UNLOCKED;
         endcase

         mod_out   <= mod_next;
         mod_valid <= run_eff;
         sym_start <= boundary;
         underrun  <= boundary && !hold_valid && !sym_valid;
         lock_err  <= fail;
      end
   end

endmodule

// File: tb/tb_qpsk_carrier_mod.sv
// Scoreboard bench for qpsk_carrier_mod: a cycle model predicts every output, a dibit queue
// checks symbol order, and fixed carrier values check the waveform at known phases.
module tb_qpsk_carrier_mod;

   logic               Clk = 1'b0;
   logic               Rst_n;
   logic signed [10:0] sin_in;
   logic [1:0]         sym_data;
   logic               sym_valid;
   logic               sym_ready;
   logic signed [11:0] mod_out;
   logic               mod_valid;
   logic               sym_start;
   logic               underrun;
   logic               lock_err;

   qpsk_carrier_mod #(
      .SW         (11),
      .PERIOD     (100),
      .DELAY      (75),
      .SYM_CYCLES (1),
      .OW         (12)
   ) dut (
      .Clk       (Clk),
      .Rst_n     (Rst_n),
      .sin_in    (sin_in),
      .sym_data  (sym_data),
      .sym_valid (sym_valid),
      .sym_ready (sym_ready),
      .mod_out   (mod_out),
      .mod_valid (mod_valid),
      .sym_start (sym_start),
      .underrun  (underrun),
      .lock_err  (lock_err)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      int mod;
      bit vld;
      bit st;
      bit und;
      bit lerr;
      int c;
      int s;
      int g;
   } exp_t;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         tab[100];
   int         gidx;
   int         cont;
   int         hf;
   exp_t       exp_q[$];
   logic [1:0] send_q[$];
   logic [1:0] dib_q[$];
   int         hist[$];

   bit         m_init = 0;
   bit         m_run;
   int         m_phase;
   int         m_prev;
   bit         m_hold_v;
   logic [1:0] m_hold;
   bit         m_cur_v;
   logic [1:0] m_cur;
   bit         act_v;
   logic [1:0] act;

   task automatic check_eq(input string tag, input int actual, input int expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
      end
   endtask

   function automatic int sgn_sum(input logic [1:0] d, input int c, input int s);
      return (d[1] ? -c : c) + (d[0] ? -s : s);
   endfunction

   // One clock: drive inputs, predict, then compare after the edge.
   task automatic step();
      exp_t       e;
      bit         r, xing, fill, enter, fail, bnd, reff, xfer, xfer_hold, cur_v;
      logic [1:0] cur;
      int         c, s;
      int         dg[4] = '{0, 12, 25, 50};
      int         dc[4] = '{1000, 728, 0, -1000};
      int         ds[4] = '{0, 684, 1000, 0};

      sym_valid = (send_q.size() > 0);
      sym_data  = (send_q.size() > 0) ? send_q[0] : 2'b00;
      sin_in    = 11'(tab[gidx]);
      r         = Rst_n;
      s         = tab[gidx];
      e         = '{default: 0};
      e.g       = gidx;

      if (m_init) check_eq("sym_ready", int'(sym_ready), int'(!m_hold_v));
      xfer = sym_valid && sym_ready;
      if (sym_valid && !sym_ready) hf++;

      if (!r) begin
         m_init   = 1;
         m_run    = 0;
         m_phase  = 0;
         m_prev   = 0;
         m_hold_v = 0;
         m_cur_v  = 0;
         hist.delete();
      end else begin
         fill      = (hist.size() >= 75);
         c         = fill ? hist[0] : 0;
         xing      = (s == 0) && (m_prev < 0);
         enter     = !m_run && xing && fill;
         fail      = m_run && (m_phase == 0) && !xing;
         bnd       = enter || (m_run && (m_phase == 0) && xing);
         reff      = enter || (m_run && !fail);
         xfer_hold = !bnd && sym_valid && !m_hold_v;
         cur_v     = m_cur_v;
         cur       = m_cur;
         if (bnd) begin
            if (m_hold_v) begin
               cur_v    = 1;
               cur      = m_hold;
               m_hold_v = 0;
            end else if (sym_valid) begin
               cur_v = 1;
               cur   = sym_data;
            end else begin
               cur_v = 0;
               e.und = 1;
            end
         end else if (fail) begin
            cur_v = 0;
         end
         if (xfer_hold) begin
            m_hold_v = 1;
            m_hold   = sym_data;
         end
         e.mod  = (reff && cur_v) ? sgn_sum(cur, c, s) : 0;
         e.vld  = reff;
         e.st   = bnd;
         e.lerr = fail;
         e.c    = c;
         e.s    = s;
         m_cur_v = cur_v;
         m_cur   = cur;
         if (enter) begin
            m_run   = 1;
            m_phase = 1;
         end else if (fail) begin
            m_run   = 0;
            m_phase = 0;
         end else if (m_run) begin
            m_phase = (m_phase + 1) % 100;
         end
         m_prev = s;
         hist.push_back(s);
         if (hist.size() > 75) void'(hist.pop_front());
      end
      exp_q.push_back(e);

      @(posedge Clk);
      #1;
      e = exp_q.pop_front();
      check_eq("mod_out", int'(mod_out), e.mod);
      check_eq("mod_valid", int'(mod_valid), int'(e.vld));
      check_eq("sym_start", int'(sym_start), int'(e.st));
      check_eq("underrun", int'(underrun), int'(e.und));
      check_eq("lock_err", int'(lock_err), int'(e.lerr));

      if (!r) begin
         dib_q.delete();
         act_v = 0;
         cont  = 0;
      end else begin
         if (xfer) begin
            dib_q.push_back(sym_data);
            void'(send_q.pop_front());
         end
         if (sym_start) begin
            if (underrun) begin
               act_v = 0;
            end else begin
               check_eq("dibit_avail", int'(dib_q.size() > 0), 1);
               if (dib_q.size() > 0) begin
                  act   = dib_q.pop_front();
                  act_v = 1;
                  check_eq("dibit_out", int'(mod_out), sgn_sum(act, e.c, e.s));
               end
            end
         end
         if (lock_err) act_v = 0;
         if (mod_valid && act_v && cont >= 75) begin
            for (int k = 0; k < 4; k++) begin
               if (e.g == dg[k])
                  check_eq($sformatf("carrier_ph%0d", dg[k]), int'(mod_out), sgn_sum(act, dc[k], ds[k]));
            end
         end
         if (mod_valid && !act_v) check_eq("idle_zero", int'(mod_out), 0);
         cont++;
      end
      gidx = (gidx + 1) % 100;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int  n;
      int  nle;
      real v;

      for (int i = 0; i < 100; i++) begin
         v = 1000.0 * $sin(2.0 * 3.14159265358979 * i / 100.0);
         v = (v >= 0.0) ? v + 1.0e-6 : v - 1.0e-6;
         tab[i] = $rtoi(v);
      end
      Rst_n     = 1'b0;
      sym_valid = 1'b0;
      sym_data  = 2'b00;
      sin_in    = '0;
      gidx      = 0;
      cont      = 0;
      hf        = 0;
      act_v     = 0;
      act       = 2'b00;

      run(3);
      Rst_n = 1'b1;
      gidx  = 0;
      send_q = '{2'b00, 2'b00, 2'b00};
      n = 0;
      while (!mod_valid && n < 300) begin
         step();
         n++;
      end
      check_eq("lock_latency", n, 101);
      check_eq("first_sym_start", int'(sym_start), 1);
      check_eq("first_lock_err", int'(lock_err), 0);
      run(200);

      send_q.push_back(2'b00);
      send_q.push_back(2'b11);
      send_q.push_back(2'b10);
      send_q.push_back(2'b01);
      hf = 0;
      run(500);
      check_eq("hold_full_seen", int'(hf > 0), 1);

      run(150);
      for (int k = 0; k < 100 && gidx != 0; k++) step();
      send_q.push_back(2'b10);
      step();
      check_eq("bypass_start", int'(sym_start), 1);
      check_eq("bypass_no_underrun", int'(underrun), 0);
      run(100);

      send_q = '{2'b01, 2'b01, 2'b01};
      run(150);
      gidx = (gidx + 7) % 100;
      cont = 0;
      nle  = 0;
      for (int i = 0; i < 250; i++) begin
         step();
         if (lock_err) nle++;
      end
      check_eq("slip_lock_err_count", nle, 1);
      check_eq("slip_relock", int'(mod_valid), 1);

      for (int k = 0; k < 100 && gidx != 40; k++) step();
      Rst_n = 1'b0;
      step();
      check_eq("rst_mid_mod_out", int'(mod_out), 0);
      check_eq("rst_mid_mod_valid", int'(mod_valid), 0);
      check_eq("rst_mid_sym_ready", int'(sym_ready), 1);
      Rst_n = 1'b1;
      send_q.push_back(2'b11);
      run(300);
      check_eq("rst_relock", int'(mod_valid), 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
